// File: rtl/cmp_result_monitor.sv
// Registered monitor for the ceq/clt/cgt comparator flags: saturating per-relation
// tallies, run-length tracking with a streak alarm, and a sticky malformed-flag error.
module cmp_result_monitor #(
  parameter int CNT_W    = 8,
  parameter int STREAK_N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             ceq,
  input  logic             clt,
  input  logic             cgt,
  input  logic             clear,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [1:0]       last_rel,
  output logic [7:0]       run_len,
  output logic             alarm,
  output logic             flag_err
);

  // Handshake: there is no backpressure; a sample is consumed on every rising
  // edge where in_valid=1 and clear=0, and its effect appears one cycle later.

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EQ   = 2'b01,
    S_LT   = 2'b10,
    S_GT   = 2'b11
  } state_t;

  localparam logic [7:0]       RUN_MAX = 8'(STREAK_N);
  localparam logic [7:0]       RUN_PRE = 8'(STREAK_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [7:0]       run_q, run_d;
  logic             alarm_q, alarm_d;
  logic             err_q, err_d;
  state_t           sample_rel;
  logic             one_hot;

  always_comb begin
    sample_rel = S_IDLE;
    one_hot    = 1'b0;
    case ({ceq, clt, cgt})
      3'b100:  begin sample_rel = S_EQ; one_hot = 1'b1; end
      3'b010:  begin sample_rel = S_LT; one_hot = 1'b1; end
      3'b001:  begin sample_rel = S_GT; one_hot = 1'b1; end
      default: begin sample_rel = S_IDLE; one_hot = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    run_d   = run_q;
    alarm_d = 1'b0;
    err_d   = err_q;
    if (clear) begin
      state_d = S_IDLE;
      eq_d    = '0;
      lt_d    = '0;
      gt_d    = '0;
      run_d   = '0;
      err_d   = 1'b0;
    end else if (in_valid) begin
      if (one_hot) begin
        if (sample_rel == state_q) begin
          if (run_q != RUN_MAX) run_d = run_q + 8'd1;
          // Only the step into saturation alarms; a fresh run starts at 1 and STREAK_N >= 2.
          alarm_d = (run_q == RUN_PRE);
        end else begin
          state_d = sample_rel;
          run_d   = 8'd1;
        end
        case (sample_rel)
          S_EQ:    if (eq_q != CNT_MAX) eq_d = eq_q + CNT_ONE;
          S_LT:    if (lt_q != CNT_MAX) lt_d = lt_q + CNT_ONE;
          S_GT:    if (gt_q != CNT_MAX) gt_d = gt_q + CNT_ONE;
          default: ;
        endcase
      end else begin
        state_d = S_IDLE;
        run_d   = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      eq_q    <= '0;
      lt_q    <= '0;
      gt_q    <= '0;
      run_q   <= '0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      run_q   <= run_d;
      alarm_q <= alarm_d;
      err_q   <= err_d;
    end
  end

  assign eq_cnt   = eq_q;
  assign lt_cnt   = lt_q;
  assign gt_cnt   = gt_q;
  assign last_rel = state_q;
  assign run_len  = run_q;
  assign alarm    = alarm_q;
  assign flag_err = err_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Bench for cmp_result_monitor: directed scenarios plus random traffic, all checked
// every cycle against a history-based reference model.
module tb_cmp_result_monitor;

  localparam int CNT_W    = 4;
  localparam int STREAK_N = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  // clock/reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0, ceq = 1'b0, clt = 1'b0, cgt = 1'b0, clear = 1'b0;
  logic [CNT_W-1:0] eq_cnt, lt_cnt, gt_cnt;
  logic [1:0]       last_rel;
  logic [7:0]       run_len;
  logic             alarm, flag_err;

  cmp_result_monitor #(.CNT_W(CNT_W), .STREAK_N(STREAK_N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ceq(ceq), .clt(clt), .cgt(cgt),
    .clear(clear), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .gt_cnt(gt_cnt),
    .last_rel(last_rel), .run_len(run_len), .alarm(alarm), .flag_err(flag_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: relation codes 1=EQ 2=LT 3=GT; the accepted-sample history
  // since the last break gives last_rel and run length directly.
  int tally[1:3];
  int hist[$];
  int m_err;
  int m_alarm;

  function automatic int tail_run();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 1; r <= 3; r++) tally[r] = 0;
    hist.delete();
    m_err = 0;
    m_alarm = 0;
  endtask

  task automatic model_edge(input logic rst, input logic v, input logic [2:0] f, input logic clr);
    int rel;
    m_alarm = 0;
    if (!rst || clr) begin
      model_reset();
    end else if (v) begin
      rel = (f == 3'b100) ? 1 : (f == 3'b010) ? 2 : (f == 3'b001) ? 3 : 0;
      if (rel == 0) begin
        m_err = 1;
        hist.delete();
      end else begin
        if (tally[rel] < CNT_MAX) tally[rel]++;
        hist.push_back(rel);
        if (hist.size() > STREAK_N + 2) void'(hist.pop_front());
        m_alarm = (tail_run() == STREAK_N) ? 1 : 0;
      end
    end
  endtask

  // scoreboard: expected output vectors queued by the model, compared after each edge
  logic [31:0] exp_q[$];

  task automatic check_outputs();
    int run;
    run = (tail_run() > STREAK_N) ? STREAK_N : tail_run();
    exp_q.push_back(tally[1]);
    exp_q.push_back(tally[2]);
    exp_q.push_back(tally[3]);
    exp_q.push_back(hist.size() ? hist[hist.size() - 1] : 0);
    exp_q.push_back(run);
    exp_q.push_back(m_alarm);
    exp_q.push_back(m_err);
    check("eq_cnt",   eq_cnt,   exp_q.pop_front());
    check("lt_cnt",   lt_cnt,   exp_q.pop_front());
    check("gt_cnt",   gt_cnt,   exp_q.pop_front());
    check("last_rel", last_rel, exp_q.pop_front());
    check("run_len",  run_len,  exp_q.pop_front());
    check("alarm",    alarm,    exp_q.pop_front());
    check("flag_err", flag_err, exp_q.pop_front());
  endtask

  // driver: apply one cycle of inputs, advance the model, check 1ns after the edge
  task automatic step(input logic v, input logic [2:0] f, input logic clr);
    in_valid = v;
    {ceq, clt, cgt} = f;
    clear = clr;
    @(posedge clk);
    model_edge(rst_n, v, f, clr);
    #1;
    check_outputs();
  endtask

  localparam logic [2:0] F_EQ = 3'b100, F_LT = 3'b010, F_GT = 3'b001;

  initial begin
    logic [2:0] f;
    int pick, last_pick;
    model_reset();

    // reset then idle (malformed flags while invalid must be ignored)
    rst_n = 1'b0;
    step(0, 3'b000, 0);
    step(0, 3'b000, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 3'b111, 0);
    check("reset_idle_rel", last_rel, 0);

    // GT streak
    step(1, F_GT, 0);
    step(1, F_GT, 0);
    step(1, F_GT, 0);
    check("gt_streak_alarm", alarm, 1);
    check("gt_streak_run", run_len, 3);
    step(1, F_GT, 0);
    check("gt_sat_no_alarm", alarm, 0);
    check("gt_sat_cnt", gt_cnt, 4);

    // run break EQ,EQ,LT,EQ
    step(1, F_EQ, 0);
    step(1, F_EQ, 0);
    step(1, F_LT, 0);
    step(1, F_EQ, 0);
    check("break_rel", last_rel, 1);
    check("break_run", run_len, 1);

    // invalid flags mid-run, then a fresh LT streak
    step(1, F_LT, 0);
    step(1, F_LT, 0);
    step(1, 3'b011, 0);
    check("bad_flag_err", flag_err, 1);
    check("bad_flag_run", run_len, 0);
    step(1, F_LT, 0);
    step(1, F_LT, 0);
    step(1, F_LT, 0);
    check("bad_then_alarm", alarm, 1);
    check("bad_err_sticky", flag_err, 1);

    // saturation of a 4-bit tally
    step(0, 3'b000, 1);
    for (int i = 0; i < 20; i++) step(1, F_EQ, 0);
    check("eq_saturated", eq_cnt, 15);

    // clear wins over a same-cycle sample
    step(1, F_GT, 1);
    check("clear_drops_gt", gt_cnt, 0);
    step(1, F_GT, 0);
    check("after_clear_gt", gt_cnt, 1);

    // reset mid-run discards everything
    step(1, F_GT, 0);
    rst_n = 1'b0;
    step(1, F_GT, 0);
    rst_n = 1'b1;

    // random traffic, biased toward repeats so streaks form
    last_pick = 1;
    for (int i = 0; i < 3000; i++) begin
      pick = ($urandom_range(0, 99) < 60) ? last_pick : int'($urandom_range(1, 3));
      last_pick = pick;
      f = (pick == 1) ? F_EQ : (pick == 2) ? F_LT : F_GT;
      if ($urandom_range(0, 99) < 6) f = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step($urandom_range(0, 99) < 75, f, $urandom_range(0, 99) < 3);
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_result_monitor.md
Name: cmp_result_monitor

Overview:
- Sequential consumer placed directly downstream of the 4-bit magnitude comparator. It samples the comparator's ceq/clt/cgt flags on a valid strobe.
- Keeps saturating per-relation tallies and tracks the run length of identical consecutive results. It pulses an alarm when a run reaches STREAK_N.
- Flags malformed (non-one-hot) flag vectors with a sticky error, so the surrounding datapath can detect trends and faults without re-reading the raw compare.

Parameters:
- CNT_W, 8: width of each tally counter eq_cnt, lt_cnt and gt_cnt (saturating).
- STREAK_N, 3: run length at which alarm pulses. Legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  sample strobe; ceq/clt/cgt are consumed only when 1.
- ceq  input  1  equal flag from comparator.
- clt  input  1  less-than flag from comparator.
- cgt  input  1  greater-than flag from comparator.
- clear  input  1  synchronous soft clear of tallies, run state and error.
- eq_cnt  output  CNT_W  number of accepted equal samples.
- lt_cnt  output  CNT_W  number of accepted less-than samples.
- gt_cnt  output  CNT_W  number of accepted greater-than samples.
- last_rel  output  2  relation of the last accepted sample: 00 none, 01 EQ, 10 LT, 11 GT.
- run_len  output  8  current run length of last_rel, saturating at STREAK_N.
- alarm  output  1  one-cycle pulse when run_len transitions to STREAK_N.
- flag_err  output  1  sticky; set by a valid sample whose flags are not exactly one-hot.

Behaviour:
- Reset: rst_n low at a rising edge clears all outputs: counters 0, last_rel 00, run_len 0, alarm 0, flag_err 0. FSM goes to S_IDLE.
- Reset mid-run discards all state. There is no partial retention.
- Priority per edge: rst_n low > clear > in_valid. clear has the same effect as reset but is a separate port. in_valid in a clear cycle is dropped.
- FSM states: S_IDLE, S_EQ, S_LT, S_GT. last_rel is the state encoding.
- Accepted sample: in_valid=1 and {ceq,clt,cgt} is exactly one-hot.
  - Same relation as the current state: run_len increments, saturating at STREAK_N.
  - Different relation, or state is S_IDLE: move to the new state, run_len becomes 1.
  - Matching tally increments, saturating at 2^CNT_W-1 (no wrap).
- Invalid sample: in_valid=1 with flags 000, or two or more flags set.
  - flag_err becomes 1 and stays 1 until clear or reset.
  - FSM goes to S_IDLE, run_len becomes 0, last_rel becomes 00.
  - No tally changes.
- in_valid=0: no state change. Flag inputs are ignored, including malformed flags.
- alarm: asserted for exactly one cycle, in the cycle after the accepting edge where run_len goes from STREAK_N-1 to STREAK_N.
  - Further same-relation samples at saturation do not re-pulse.
  - A new run of any relation can pulse again once it reaches STREAK_N.
- Latency: every output is registered. An effect is visible on the outputs one cycle after the sampling edge.
- Throughput: one sample per cycle. Back-to-back in_valid is fully supported.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, keep in_valid=0 for 5 cycles -> all counters 0, last_rel=00, run_len=0, alarm=0, flag_err=0.
- GT streak, STREAK_N=3: three consecutive valid samples with cgt=1 -> gt_cnt=3, run_len=1,2,3, alarm high for exactly one cycle after the third edge. A fourth cgt sample -> gt_cnt=4, run_len=3, no alarm.
- Run break: sequence EQ,EQ,LT,EQ -> eq_cnt=3, lt_cnt=1, final last_rel=01, run_len=1, no alarm.
- Invalid flags: after LT,LT, apply valid {ceq,clt,cgt}=011 -> flag_err=1, last_rel=00, run_len=0, lt_cnt=2. Then 3x LT -> alarm pulses and flag_err stays 1.
- Saturation, CNT_W=4: 20 valid EQ samples -> eq_cnt holds at 15 and never wraps.
- Clear vs valid in the same cycle: clear=1 with valid cgt=1 -> all counters 0, last_rel=00, flag_err=0, and the sample is not counted. The next cycle, a valid cgt sample -> gt_cnt=1.
